cbd_stream: RTL and testbench

Streaming centered-binomial-distribution sampler for Kyber noise polynomials. It accepts PRF output words over a valid/ready handshake and keeps them in a bit buffer. It emits LANES coefficients per beat, already reduced into [0, Q-1], with runtime-selectable eta (2 or 3). It sits between the SHAKE/PRF output stream and the polynomial RAM / NTT input, and produces one full 256-coefficient polynomial per start.

---
 rtl/cbd_stream_pkg.sv | 17 +
 rtl/cbd_stream_coef.sv | 31 +++
 rtl/cbd_stream.sv | 181 ++++++++++++++++++
 tb/tb_cbd_stream.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbd_stream_pkg.sv
// Shared Kyber constants, eta codes and FSM state type for the CBD sampler.
package cbd_stream_pkg;

  localparam int unsigned KYBER_N    = 256;
  localparam int unsigned KYBER_Q    = 3329;
  localparam int unsigned CBD_COEF_W = 12;

  localparam logic [1:0] ETA2 = 2'd2;
  localparam logic [1:0] ETA3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/cbd_stream_coef.sv
// One CBD lane: popcount difference of two eta-bit groups, folded into [0, Q-1].
module cbd_coef
  import cbd_stream_pkg::*;
#(
  parameter int unsigned COEF_W = CBD_COEF_W,
  parameter int unsigned Q      = KYBER_Q
) (
  input  logic [5:0]        slice_i,
  input  logic [1:0]        eta_i,
  output logic [COEF_W-1:0] coef_o
);

  logic [1:0] a;
  logic [1:0] b;

  always_comb begin
    if (eta_i == ETA3) begin
      a = 2'(slice_i[0]) + 2'(slice_i[1]) + 2'(slice_i[2]);
      b = 2'(slice_i[3]) + 2'(slice_i[4]) + 2'(slice_i[5]);
    end else begin
      a = 2'(slice_i[0]) + 2'(slice_i[1]);
      b = 2'(slice_i[2]) + 2'(slice_i[3]);
    end
    if (a >= b) begin
      coef_o = COEF_W'(a - b);
    end else begin
      coef_o = COEF_W'(Q) - COEF_W'(b - a);
    end
  end

endmodule

// File: rtl/cbd_stream.sv
// Streaming centered-binomial sampler: PRF words in, LANES mod-Q coefficients
// per beat out, one 256-coefficient polynomial per start.
module cbd_stream
  import cbd_stream_pkg::*;
#(
  parameter int unsigned IN_W   = 64,
  parameter int unsigned LANES  = 4,
  parameter int unsigned COEF_W = CBD_COEF_W,
  parameter int unsigned Q      = KYBER_Q
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [1:0]                i_eta,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [IN_W-1:0]           i_in_data,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [LANES*COEF_W-1:0]   o_out_data,
  output logic [7:0]                o_out_idx,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err
);

  localparam int unsigned BUF_W  = IN_W + 6 * LANES;
  localparam int unsigned CNT_W  = $clog2(BUF_W + 1);
  localparam int unsigned W2     = 4 * KYBER_N / IN_W;
  localparam int unsigned W3     = 6 * KYBER_N / IN_W;
  localparam int unsigned WC_W   = $clog2(W3 + 1);
  localparam int unsigned NBEATS = KYBER_N / LANES;
  localparam int unsigned BC_W   = $clog2(NBEATS + 1);

  state_t                    state_q, state_d;
  logic [1:0]                eta_q, eta_d;
  logic [BUF_W-1:0]          bitbuf_q, bitbuf_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WC_W-1:0]           words_q, words_d;
  logic [BC_W-1:0]           beats_q, beats_d;
  logic                      valid_q, valid_d;
  logic [LANES*COEF_W-1:0]   data_q, data_d;
  logic [7:0]                idx_q, idx_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic                      eta3;
  logic                      eta_legal;
  logic [CNT_W-1:0]          beat_bits;
  logic [WC_W-1:0]           words_need;
  logic                      running;
  logic                      in_ready;
  logic                      in_fire;
  logic                      out_fire;
  logic                      load;
  logic                      last_out;
  logic [LANES*COEF_W-1:0]   coef_vec;
  logic [BUF_W-1:0]          bitbuf_sh;
  logic [CNT_W-1:0]          cnt_sh;

  assign eta3       = (eta_q == ETA3);
  assign eta_legal  = (i_eta == ETA2) || (i_eta == ETA3);
  assign beat_bits  = eta3 ? CNT_W'(6 * LANES) : CNT_W'(4 * LANES);
  assign words_need = eta3 ? WC_W'(W3) : WC_W'(W2);
  assign running    = (state_q != ST_IDLE);
  assign in_ready   = (state_q == ST_RUN) && (words_q < words_need) &&
                      ((CNT_W + 1)'(cnt_q) + (CNT_W + 1)'(IN_W) <= (CNT_W + 1)'(BUF_W));
  assign in_fire    = in_ready && i_in_valid;
  assign out_fire   = valid_q && i_out_ready;
  assign load       = running && (cnt_q >= beat_bits) && (beats_q < BC_W'(NBEATS)) &&
                      (!valid_q || i_out_ready);
  assign last_out   = out_fire && (idx_q == 8'(KYBER_N - LANES));

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [5:0] slice;
    assign slice = eta3 ? bitbuf_q[6*j +: 6] : {2'b00, bitbuf_q[4*j +: 4]};
    cbd_coef #(
      .COEF_W (COEF_W),
      .Q      (Q)
    ) u_coef (
      .slice_i (slice),
      .eta_i   (eta_q),
      .coef_o  (coef_vec[j*COEF_W +: COEF_W])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_start && eta_legal) state_d = ST_RUN;
      ST_RUN:   if (in_fire && (words_q == words_need - WC_W'(1))) state_d = ST_DRAIN;
      ST_DRAIN: if (last_out) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    eta_d   = eta_q;
    words_d = words_q;
    beats_d = beats_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if ((state_q == ST_IDLE) && i_start) begin
      if (eta_legal) eta_d = i_eta;
      else           err_d = 1'b1;
    end

    // Consume first, then append the new word just above the surviving bits,
    // so a same-cycle load and input never overlap or leave a gap.
    bitbuf_sh = load ? (bitbuf_q >> beat_bits) : bitbuf_q;
    cnt_sh    = load ? (cnt_q - beat_bits) : cnt_q;
    bitbuf_d  = bitbuf_sh;
    cnt_d     = cnt_sh;
    if (in_fire) begin
      bitbuf_d = bitbuf_sh | (BUF_W'(i_in_data) << cnt_sh);
      cnt_d    = cnt_sh + CNT_W'(IN_W);
      words_d  = words_q + WC_W'(1);
    end

    if (load) begin
      data_d  = coef_vec;
      beats_d = beats_q + BC_W'(1);
      valid_d = 1'b1;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
    if (out_fire) idx_d = idx_q + 8'(LANES);

    if (last_out) begin
      bitbuf_d = '0;
      cnt_d    = '0;
      words_d  = '0;
      beats_d  = '0;
      valid_d  = 1'b0;
      data_d   = '0;
      idx_d    = '0;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      eta_q    <= '0;
      bitbuf_q <= '0;
      cnt_q    <= '0;
      words_q  <= '0;
      beats_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      eta_q    <= eta_d;
      bitbuf_q <= bitbuf_d;
      cnt_q    <= cnt_d;
      words_q  <= words_d;
      beats_q  <= beats_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_in_ready  = in_ready;
  assign o_out_valid = valid_q;
  assign o_out_data  = data_q;
  assign o_out_idx   = idx_q;
  assign o_busy      = running;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_cbd_stream.sv
// Randomised bench for cbd_stream against a bit-accounting reference model.
module tb_cbd_stream;

  localparam int unsigned IN_W   = 64;
  localparam int unsigned LANES  = 4;
  localparam int unsigned COEF_W = 12;
  localparam int unsigned Q      = 3329;
  localparam int unsigned BUF_W  = IN_W + 6 * LANES;
  localparam int unsigned NBEATS = 256 / LANES;
  localparam int unsigned NBYTES = 192;
  localparam int unsigned DW     = LANES * COEF_W;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_start = 1'b0;
  logic [1:0]      i_eta = 2'd0;
  logic            i_in_valid = 1'b0;
  logic            o_in_ready;
  logic [IN_W-1:0] i_in_data = '0;
  logic            o_out_valid;
  logic            i_out_ready = 1'b0;
  logic [DW-1:0]   o_out_data;
  logic [7:0]      o_out_idx;
  logic            o_busy;
  logic            o_done;
  logic            o_err;

  cbd_stream #(
    .IN_W   (IN_W),
    .LANES  (LANES),
    .COEF_W (COEF_W),
    .Q      (Q)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_eta       (i_eta),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_out_idx   (o_out_idx),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0]  stim [NBYTES];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  bit          active = 1'b0;
  bit          done_exp = 1'b0;
  bit          err_exp = 1'b0;
  int unsigned cur_eta = 2;
  int unsigned exp_ptr = 0;
  int unsigned in_taken = 0;
  int unsigned done_cnt = 0;
  int unsigned err_cnt = 0;
  logic [DW-1:0] first_beat = '0;
  logic [DW-1:0] expv;
  int            bits_held;
  bit            exp_rdy;

  int unsigned vprob = 100;
  int unsigned rprob = 100;
  int unsigned stall_cycles = 0;

  function automatic int unsigned model_coef(int unsigned i, int unsigned eta);
    int unsigned a = 0;
    int unsigned b = 0;
    int unsigned base = 2 * eta * i;
    for (int unsigned k = 0; k < eta; k++) begin
      if (stim[(base + k) / 8][(base + k) % 8] == 1'b1) a++;
      if (stim[(base + eta + k) / 8][(base + eta + k) % 8] == 1'b1) b++;
    end
    return (a >= b) ? (a - b) : (Q - (b - a));
  endfunction

  function automatic int unsigned words_for(int unsigned eta);
    return 2 * eta * 256 / IN_W;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and per-cycle compare, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (i_rst) begin
      chk("reset_outputs",
          64'({o_in_ready, o_out_valid, o_out_data, o_out_idx, o_busy, o_done, o_err}), 64'(0));
      active   = 1'b0;
      done_exp = 1'b0;
      err_exp  = 1'b0;
      exp_ptr  = 0;
      in_taken = 0;
    end else begin
      chk("busy", 64'(o_busy), 64'(active));
      chk("done", 64'(o_done), 64'(done_exp));
      chk("err", 64'(o_err), 64'(err_exp));
      if (o_done && done_exp) begin
        done_cnt++;
        chk("words_taken", 64'(in_taken), 64'(words_for(cur_eta)));
      end
      if (o_err && err_exp) err_cnt++;

      if (active) begin
        bits_held = int'(in_taken * IN_W) -
                    int'((exp_ptr + (o_out_valid ? 1 : 0)) * 2 * cur_eta * LANES);
        exp_rdy = (in_taken < words_for(cur_eta)) && (bits_held + int'(IN_W) <= int'(BUF_W));
        chk("in_ready", 64'(o_in_ready), 64'(exp_rdy));
        if (o_out_valid) begin
          for (int unsigned j = 0; j < LANES; j++)
            expv[j*COEF_W +: COEF_W] = COEF_W'(model_coef(exp_ptr * LANES + j, cur_eta));
          chk("out_idx", 64'(o_out_idx), 64'(exp_ptr * LANES));
          chk("out_data", 64'(o_out_data), 64'(expv));
          if (exp_ptr == 0) first_beat = o_out_data;
        end
      end else begin
        chk("idle_handshake", 64'({o_in_ready, o_out_valid}), 64'(0));
      end

      done_exp = 1'b0;
      err_exp  = 1'b0;
      if (active) begin
        if (o_in_ready && i_in_valid) in_taken++;
        if (o_out_valid && i_out_ready) begin
          exp_ptr++;
          if (exp_ptr == NBEATS) begin
            active   = 1'b0;
            done_exp = 1'b1;
          end
        end
      end else if (i_start) begin
        if (i_eta >= 2'd2) begin
          active   = 1'b1;
          cur_eta  = int'(i_eta);
          exp_ptr  = 0;
          in_taken = 0;
        end else begin
          err_exp = 1'b1;
        end
      end
    end
  end

  // Input/output handshake driver.
  always @(posedge i_clk) begin
    #1;
    if (stall_cycles > 0) begin
      i_out_ready = 1'b0;
      stall_cycles--;
    end else begin
      i_out_ready = ($urandom_range(99) < rprob);
    end
    i_in_valid = ($urandom_range(99) < vprob);
    for (int unsigned b = 0; b < IN_W / 8; b++)
      i_in_data[8*b +: 8] = (in_taken * (IN_W / 8) + b < NBYTES) ? stim[in_taken * (IN_W / 8) + b] : 8'h00;
  end

  task automatic fill(input logic [7:0] v);
    for (int unsigned k = 0; k < NBYTES; k++) stim[k] = v;
  endtask

  task automatic fill_rand();
    for (int unsigned k = 0; k < NBYTES; k++) stim[k] = 8'($urandom);
  endtask

  task automatic do_start(input logic [1:0] eta);
    i_eta   = eta;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic recover();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic wait_done(input int unsigned d0);
    int unsigned n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (done_cnt == d0) begin
      chk("done_timeout", 64'(0), 64'(1));
      recover();
    end
  endtask

  task automatic wait_beats(input int unsigned nb);
    int unsigned n = 0;
    while (exp_ptr < nb && n < 2000) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (exp_ptr < nb) begin
      chk("beat_timeout", 64'(exp_ptr), 64'(nb));
      recover();
    end
  endtask

  task automatic run_poly(input logic [1:0] eta);
    int unsigned d0 = done_cnt;
    do_start(eta);
    wait_done(d0);
  endtask

  initial begin
    int unsigned d0;
    int unsigned e0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    fill(8'h03);
    chk("pin_e2_03_c0", 64'(model_coef(0, 2)), 64'(2));
    chk("pin_e2_03_c1", 64'(model_coef(1, 2)), 64'(0));
    fill(8'h0C);
    chk("pin_e2_0c_c0", 64'(model_coef(0, 2)), 64'(3327));
    fill(8'h00); stim[0] = 8'h07;
    chk("pin_e3_07_c0", 64'(model_coef(0, 3)), 64'(3));
    chk("pin_e3_07_c1", 64'(model_coef(1, 3)), 64'(0));
    stim[0] = 8'h38;
    chk("pin_e3_38_c0", 64'(model_coef(0, 3)), 64'(3326));

    fill(8'h00);
    run_poly(2'd2);
    chk("t1_first", 64'(first_beat), 64'(0));

    fill(8'h03);
    run_poly(2'd2);
    chk("t2_first_03", 64'(first_beat), 64'h0000_0000_0200_0002);
    fill(8'h0C);
    run_poly(2'd2);
    chk("t2_first_0c", 64'(first_beat), 64'h0000_000C_FF00_0CFF);

    fill(8'h00); stim[0] = 8'h07;
    run_poly(2'd3);
    chk("t3_first_07", 64'(first_beat), 64'h3);
    stim[0] = 8'h38;
    run_poly(2'd3);
    chk("t3_first_38", 64'(first_beat), 64'hCFE);

    fill_rand();
    vprob = 100; rprob = 100;
    d0 = done_cnt;
    do_start(2'd2);
    wait_beats(12);
    stall_cycles = 10;
    repeat (9) @(posedge i_clk);
    #1;
    chk("t4_stall_in_ready", 64'(o_in_ready), 64'(0));
    chk("t4_stall_valid", 64'(o_out_valid), 64'(1));
    wait_done(d0);

    e0 = err_cnt;
    do_start(2'd1);
    repeat (3) @(posedge i_clk);
    #1;
    chk("t5_err_count", 64'(err_cnt), 64'(e0 + 1));
    chk("t5_busy", 64'(o_busy), 64'(0));
    do_start(2'd0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("t5_err_count0", 64'(err_cnt), 64'(e0 + 2));

    fill_rand();
    d0 = done_cnt;
    do_start(2'd3);
    wait_beats(10);
    do_start(2'd2);
    wait_done(d0);

    vprob = 70; rprob = 60;
    for (int unsigned r = 0; r < 4; r++) begin
      fill_rand();
      run_poly(($urandom_range(1) == 0) ? 2'd2 : 2'd3);
    end

    vprob = 100; rprob = 100;
    fill_rand();
    d0 = done_cnt;
    do_start(2'd2);
    wait_beats(5);
    i_rst = 1'b1;
    #1;
    chk("t6_rst_outputs",
        64'({o_in_ready, o_out_valid, o_out_data, o_out_idx, o_busy, o_done, o_err}), 64'(0));
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    chk("t6_no_done", 64'(done_cnt), 64'(d0));
    fill_rand();
    vprob = 80; rprob = 80;
    run_poly(2'd3);
    chk("t6_words", 64'(in_taken), 64'(24));
    chk("t6_done_count", 64'(done_cnt), 64'(d0 + 1));

    repeat (3) @(posedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
